// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies with shift-add and divides with a restoring divider, one bit per
// cycle. Divide by zero and signed overflow are answered without iterating.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     busy,
  output logic                     ResultValid,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] ITERATIONS = CW'(DATA_WIDTH);
  localparam logic [W-1:0]  MIN_INT    = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state_q;
  logic [CW-1:0]            count_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     neg_q;
  logic [W-1:0]             opnd_q;
  logic [2*W-1:0]           acc_q;
  logic                     busy_q;
  logic                     valid_q;
  logic [W-1:0]             result_q;

  logic           signA, signB, negIn;
  logic [W-1:0]   magA, magB;
  logic           divZero, divOvf, special;
  logic [W-1:0]   specialRes;
  logic [W:0]     mulSum;
  logic [W:0]     remShift;
  logic [W:0]     remDiff;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] prodSigned;
  logic [W-1:0]   quot, rem;
  logic [W-1:0]   result_d;

  // Decode the incoming op: operand signs, magnitudes, result sign and the non-iterated cases.
  always_comb begin
    signA = 1'b0;
    signB = 1'b0;
    case (Operation)
      3'b001:         begin signA = SrcA[W-1]; signB = SrcB[W-1]; end
      3'b010:         begin signA = SrcA[W-1]; end
      3'b100, 3'b110: begin signA = SrcA[W-1]; signB = SrcB[W-1]; end
      default:        begin signA = 1'b0; signB = 1'b0; end
    endcase
    magA       = signA ? -SrcA : SrcA;
    magB       = signB ? -SrcB : SrcB;
    negIn      = (Operation == 3'b110) ? signA : (signA ^ signB);
    divZero    = Operation[2] && (SrcB == '0);
    divOvf     = Operation[2] && !Operation[0] && (SrcA == MIN_INT) && (SrcB == '1);
    special    = divZero || divOvf;
    specialRes = divZero ? (Operation[1] ? SrcA : '1) : (Operation[1] ? '0 : MIN_INT);
  end

  // One iteration step: the accumulator holds {high/remainder, multiplier/dividend}.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    remShift = {acc_q[2*W-1:W], acc_q[W-1]};
    remDiff  = remShift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!remDiff[W]) acc_d = {remDiff[W-1:0], acc_q[W-2:0], 1'b1};
      else             acc_d = {remShift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      acc_d = {mulSum, acc_q[W-1:1]};
    end
    prodSigned = neg_q ? -acc_d : acc_d;
    quot       = acc_d[W-1:0];
    rem        = acc_d[2*W-1:W];
    case (op_q)
      3'b000:                 result_d = prodSigned[W-1:0];
      3'b001, 3'b010, 3'b011: result_d = prodSigned[2*W-1:W];
      3'b100, 3'b101:         result_d = neg_q ? -quot : quot;
      default:                result_d = neg_q ? -rem : rem;
    endcase
  end

  // Control FSM with registered busy/valid/result; flush aborts, reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q   <= Operation;
              neg_q  <= negIn;
              busy_q <= 1'b1;
              if (special) begin
                state_q  <= DONE;
                valid_q  <= 1'b1;
                result_q <= specialRes;
              end else begin
                state_q <= CALC;
                count_q <= ITERATIONS;
                opnd_q  <= Operation[2] ? magB : magA;
                acc_q   <= {{W{1'b0}}, (Operation[2] ? magA : magB)};
              end
            end
          end
          CALC: begin
            acc_q   <= acc_d;
            count_q <= count_q - 1'b1;
            if (count_q == CW'(1)) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= result_d;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign ResultValid = valid_q;
  assign Result      = result_q;

endmodule
